preg_release_queue: RTL and testbench
=====================================

Name: preg_release_queue

Overview:
- Buffers physical-register tags retired at commit and returns them to the free_list one per cycle on its free_en/free_phys port.
- Sits between the ROB commit stage (two commit lanes per cycle) and the free_list release port, which accepts one tag per cycle.
- Absorbs commit bursts, keeps release order, drops the hard-wired zero mapping, and flags double releases and overflow.

Parameters:
- PHYS_REGS, 64, number of physical registers (matches core_pkg::PREGS); tag width 6 bits.
- DEPTH, 16, queue entries; must be a power of two and at least 2.
- ZERO_PREG, 0, physical tag of XZR; this tag is never released.

Ports:
- clk  input  1  core clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- commit0_valid  input  1  lane 0 retires an instruction with an old mapping to release
- commit0_old_phys  input  6  tag to release on lane 0
- commit1_valid  input  1  lane 1 (younger) release request
- commit1_old_phys  input  6  tag to release on lane 1
- commit_ready  output  1  queue can accept both lanes this cycle
- free_en  output  1  registered; one tag released to free_list this cycle
- free_phys  output  6  registered; tag being released
- count  output  $clog2(DEPTH+1)  entries currently held (excludes output register)
- dbl_free_err  output  1  sticky; a tag already pending was offered again
- overflow_err  output  1  sticky; a lane was valid while commit_ready was low

Behaviour:
- Reset (reset==0 at clk edge): clear head, tail, and count; clear pending mask (PHYS_REGS bits); clear free_en, free_phys, and both error flags. Reset takes effect mid-burst; queued tags are discarded and no free_en is emitted on the following cycle.
- commit_ready = (DEPTH - count) >= 2. This is combinational from count only and does not depend on a same-cycle pop.
- Enqueue at edge E, only when commit_ready==1. Process lane 0 first, then lane 1. For each valid lane:
  - If tag == ZERO_PREG, drop it silently.
  - Else if pending[tag]==1, or lane 1 repeats lane 0's tag in the same cycle, drop it and set dbl_free_err.
  - Else write the tag to mem[tail], increment tail mod DEPTH, and set pending[tag].
  - Two accepted lanes occupy consecutive slots, lane 0 first.
- Any valid lane while commit_ready==0: drop all lanes offered that cycle and set overflow_err. Nothing is enqueued and pending is unchanged.
- Dequeue at every edge where count>0 (count as sampled before the edge):
  - free_phys <= mem[head]; free_en <= 1.
  - Increment head mod DEPTH; clear pending[mem[head]].
  - When count==0, free_en <= 0 and free_phys holds its last value.
- Enqueue and dequeue may happen on the same edge. count_next = count + accepted - popped (range 0..DEPTH). A pop clearing pending[x] on the same edge that lane offers x: the offer is treated as a double free (pending is sampled pre-edge).
- Latency: tag sampled on a commit lane at edge E, queue empty → free_en=1 with that tag during the cycle after edge E+1. Throughput is one tag per cycle.
- Order: tags appear on free_phys in exact acceptance order.
- Error flags stay set until reset.
- Pointers use log2(DEPTH) bits and wrap naturally. Full (count==DEPTH) and count==DEPTH-1 both hold commit_ready low.

Test Plan:
- Reset, then lane 0 valid tag 33 for one cycle → commit_ready=1 throughout; free_en=1, free_phys=33 exactly two cycles after the commit edge, for one cycle; count returns to 0.
- Lanes 0 and 1 valid with tags 40 and 41 for 4 consecutive cycles (tags 40..47) → free_phys sequence 40,41,...,47 on 8 consecutive cycles; count peaks at 5; no errors.
- Lane 0 offers tag 0 (ZERO_PREG), lane 1 offers tag 50 → only 50 is released; count increments by 1; no error flags set.
- Lane 0 tag 20 and lane 1 tag 20 in the same cycle; later, tag 20 is offered while still queued → 20 released exactly once; dbl_free_err=1 and stays 1.
- Hold release from draining by filling to count=15 with DEPTH=16 (2 enqueues per cycle against 1 pop), then offer a further pair → commit_ready=0; offered pair absent from output; overflow_err=1; all earlier tags released in order.
- Drive reset=0 for one cycle mid-drain with count=6 → next cycle free_en=0, count=0, both error flags 0; a new tag 9 offered afterwards is released normally.

Source files
------------

// File: rtl/preg_release_queue.sv
// preg_release_queue
//   Collects physical-register tags freed at commit (two lanes per cycle) and
//   hands them back to the free list one per cycle, in acceptance order.
//   The zero register's tag is silently dropped. Repeated tags and offers made
//   while the queue cannot take a full pair are dropped and flagged.
//
// Ports
//   clk               core clock, rising edge
//   reset             synchronous reset, active low
//   commit0_valid     lane 0 release request
//   commit0_old_phys  lane 0 tag
//   commit1_valid     lane 1 (younger) release request
//   commit1_old_phys  lane 1 tag
//   commit_ready      at least two free slots (depends on count only)
//   free_en           registered release strobe to the free list
//   free_phys         registered released tag
//   count             entries held, output register excluded
//   dbl_free_err      sticky: an already-pending tag was offered again
//   overflow_err      sticky: a lane was valid while commit_ready was low
module preg_release_queue #(
  parameter int PHYS_REGS = 64,
  parameter int DEPTH     = 16,
  parameter int ZERO_PREG = 0,
  localparam int TW = $clog2(PHYS_REGS),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          commit0_valid,
  input  logic [TW-1:0] commit0_old_phys,
  input  logic          commit1_valid,
  input  logic [TW-1:0] commit1_old_phys,
  output logic          commit_ready,
  output logic          free_en,
  output logic [TW-1:0] free_phys,
  output logic [CW-1:0] count,
  output logic          dbl_free_err,
  output logic          overflow_err
);

  localparam logic [TW-1:0] ZERO_TAG = TW'(ZERO_PREG);

  logic [TW-1:0]        mem [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [PHYS_REGS-1:0] pending;

  logic          lane0_live, lane1_live;
  logic          lane0_dup, lane1_dup;
  logic          lane0_push, lane1_push;
  logic          dbl_hit, ovf_hit;
  logic          pop;
  logic [TW-1:0] head_tag;
  logic [PW-1:0] tail1;

  // Ready only looks at count: a pop on the same edge does not help.
  assign commit_ready = (count <= CW'(DEPTH - 2));

  assign lane0_live = commit0_valid && (commit0_old_phys != ZERO_TAG);
  assign lane1_live = commit1_valid && (commit1_old_phys != ZERO_TAG);

  // pending is the pre-edge view, so a tag popped on this edge still counts
  // as pending. Lane 1 repeating lane 0 is a duplicate even if lane 0 itself
  // was rejected.
  assign lane0_dup = pending[commit0_old_phys];
  assign lane1_dup = pending[commit1_old_phys] ||
                     (commit0_valid && (commit1_old_phys == commit0_old_phys));

  assign lane0_push = commit_ready && lane0_live && !lane0_dup;
  assign lane1_push = commit_ready && lane1_live && !lane1_dup;

  assign dbl_hit = commit_ready && ((lane0_live && lane0_dup) ||
                                    (lane1_live && lane1_dup));
  assign ovf_hit = !commit_ready && (commit0_valid || commit1_valid);

  assign pop      = (count != '0);
  assign head_tag = mem[head];
  assign tail1    = tail + PW'(lane0_push);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      pending      <= '0;
      free_en      <= 1'b0;
      free_phys    <= '0;
      dbl_free_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      free_en <= pop;
      if (pop) begin
        free_phys         <= head_tag;
        head              <= head + PW'(1);
        pending[head_tag] <= 1'b0;
      end
      // A pushed tag was not pending pre-edge, so it can never be the tag
      // being popped; set and clear never collide on one bit.
      if (lane0_push) pending[commit0_old_phys] <= 1'b1;
      if (lane1_push) pending[commit1_old_phys] <= 1'b1;
      tail  <= tail + PW'(lane0_push) + PW'(lane1_push);
      count <= count + CW'(lane0_push) + CW'(lane1_push) - CW'(pop);
      if (dbl_hit) dbl_free_err <= 1'b1;
      if (ovf_hit) overflow_err <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (lane0_push) mem[tail]  <= commit0_old_phys;
    if (lane1_push) mem[tail1] <= commit1_old_phys;
  end

endmodule

// File: tb/tb_preg_release_queue.sv
module tb_preg_release_queue;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       commit0_valid = 1'b0;
  logic [5:0] commit0_old_phys = '0;
  logic       commit1_valid = 1'b0;
  logic [5:0] commit1_old_phys = '0;
  logic       commit_ready;
  logic       free_en;
  logic [5:0] free_phys;
  logic [4:0] count;
  logic       dbl_free_err;
  logic       overflow_err;

  preg_release_queue #(.PHYS_REGS(64), .DEPTH(DEPTH), .ZERO_PREG(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .commit0_valid    (commit0_valid),
    .commit0_old_phys (commit0_old_phys),
    .commit1_valid    (commit1_valid),
    .commit1_old_phys (commit1_old_phys),
    .commit_ready     (commit_ready),
    .free_en          (free_en),
    .free_phys        (free_phys),
    .count            (count),
    .dbl_free_err     (dbl_free_err),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of held tags plus a set of pending tags.
  bit [5:0] mq[$];
  bit [5:0] sb[$];
  bit       pend[64];
  bit       m_dbl = 1'b0;
  bit       m_ovf = 1'b0;
  bit       m_rdy;
  bit       m_did_pop;
  bit [5:0] m_tag;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      sb.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_dbl = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_rdy     = (DEPTH - mq.size()) >= 2;
      m_did_pop = mq.size() > 0;
      if (commit0_valid || commit1_valid) begin
        if (!m_rdy) m_ovf = 1'b1;
        else begin
          if (commit0_valid && commit0_old_phys != 0) begin
            if (pend[commit0_old_phys]) m_dbl = 1'b1;
            else begin
              mq.push_back(commit0_old_phys);
              pend[commit0_old_phys] = 1'b1;
            end
          end
          if (commit1_valid && commit1_old_phys != 0) begin
            if (pend[commit1_old_phys] ||
                (commit0_valid && commit1_old_phys == commit0_old_phys))
              m_dbl = 1'b1;
            else begin
              mq.push_back(commit1_old_phys);
              pend[commit1_old_phys] = 1'b1;
            end
          end
        end
      end
      // The oldest held tag leaves; new pushes went to the back, so the
      // front is always a tag that was held before this edge.
      if (m_did_pop) begin
        m_tag = mq.pop_front();
        pend[m_tag] = 1'b0;
        sb.push_back(m_tag);
      end
    end
  end

  // Monitor: consumes expected releases whenever the DUT presents one.
  bit [5:0] exp_tag;
  always @(negedge clk) begin
    if (free_en) begin
      if (sb.size() == 0) chk("free_en_unexpected", 1, 0);
      else begin
        exp_tag = sb.pop_front();
        chk("free_phys", int'(free_phys), int'(exp_tag));
      end
    end else if (sb.size() != 0) begin
      chk("free_en_missing", 0, 1);
      sb.delete();
    end
    chk("count", int'(count), mq.size());
    chk("commit_ready", int'(commit_ready), ((DEPTH - mq.size()) >= 2) ? 1 : 0);
    chk("dbl_free_err", int'(dbl_free_err), int'(m_dbl));
    chk("overflow_err", int'(overflow_err), int'(m_ovf));
  end

  task automatic cyc(input bit v0, input int t0, input bit v1, input int t1);
    @(negedge clk);
    commit0_valid    = v0;
    commit0_old_phys = 6'(t0);
    commit1_valid    = v1;
    commit1_old_phys = 6'(t1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_free_en", int'(free_en), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(commit_ready), 1);
    reset = 1'b1;

    // single tag latency
    cyc(1, 33, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t1_en_e0", int'(free_en), 0);
    chk("t1_count", int'(count), 1);
    cyc(0, 0, 0, 0);
    chk("t1_en_e1", int'(free_en), 1);
    chk("t1_phys", int'(free_phys), 33);
    cyc(0, 0, 0, 0);
    chk("t1_en_e2", int'(free_en), 0);
    chk("t1_count_end", int'(count), 0);

    // dual-lane burst
    for (int k = 0; k < 4; k++) cyc(1, 40 + 2*k, 1, 41 + 2*k);
    cyc(0, 0, 0, 0);
    chk("t2_count_peak", int'(count), 5);
    idle(10);
    chk("t2_no_dbl", int'(dbl_free_err), 0);
    chk("t2_no_ovf", int'(overflow_err), 0);

    // zero tag dropped
    cyc(1, 0, 1, 50);
    cyc(0, 0, 0, 0);
    chk("t3_count", int'(count), 1);
    idle(4);
    chk("t3_no_dbl", int'(dbl_free_err), 0);

    // double free, same cycle and while queued
    cyc(1, 11, 1, 12);
    cyc(1, 20, 1, 20);
    cyc(1, 20, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t4_dbl_set", int'(dbl_free_err), 1);
    idle(6);
    chk("t4_dbl_sticky", int'(dbl_free_err), 1);

    // fill to 15, then overflow
    for (int k = 0; k < 14; k++) cyc(1, 2*k + 1, 1, 2*k + 2);
    cyc(1, 60, 1, 61);
    chk("t5_count_full", int'(count), 15);
    chk("t5_ready_low", int'(commit_ready), 0);
    cyc(0, 0, 0, 0);
    chk("t5_ovf", int'(overflow_err), 1);
    idle(20);

    // reset mid-drain
    for (int k = 0; k < 5; k++) cyc(1, 30 + 2*k, 1, 31 + 2*k);
    @(negedge clk);
    chk("t6_count_pre", int'(count), 6);
    commit0_valid = 1'b0;
    commit1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_free_en", int'(free_en), 0);
    chk("t6_count", int'(count), 0);
    chk("t6_dbl", int'(dbl_free_err), 0);
    chk("t6_ovf", int'(overflow_err), 0);
    reset = 1'b1;
    cyc(1, 9, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_en9", int'(free_en), 1);
    chk("t6_phys9", int'(free_phys), 9);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        @(negedge clk);
        commit0_valid = 1'b0;
        commit1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else if (r < 15) begin
        idle(int'($urandom_range(1, 6)));
      end else begin
        int t0, t1;
        t0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 23))
                                         : int'($urandom_range(0, 63));
        t1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 23))
                                         : int'($urandom_range(0, 63));
        cyc(($urandom_range(0, 3) != 0), t0, ($urandom_range(0, 3) != 0), t1);
      end
    end
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
